// File: rtl/exp_pkg.sv
// Shared types and constants for the exp job dispatcher and its
// hold/watchdog counter.
package exp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } exp_state_e;

    localparam int EXP_DW_DEF         = 16;
    localparam int EXP_START_HOLD_MIN = 2;
    localparam int EXP_START_HOLD_MAX = 15;
    localparam int EXP_HOLD_W         = 4;

    // Keeps the start pulse inside what the 4-bit hold counter and the
    // accelerator's Idle->Init->load sequence can support.
    function automatic int exp_clamp_hold(input int v);
        if (v < EXP_START_HOLD_MIN) begin
            return EXP_START_HOLD_MIN;
        end
        if (v > EXP_START_HOLD_MAX) begin
            return EXP_START_HOLD_MAX;
        end
        return v;
    endfunction

endpackage

// File: rtl/exp_hold_counter.sv
// Loadable down-counter with a zero flag; saturates at zero.
// Used for the start-hold countdown and the WAIT watchdog.
module exp_hold_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/exp_job_dispatcher.sv
// Start/done initiator for the series-evaluation accelerator.
// Optional WAIT watchdog: define EXP_DISPATCH_TIMEOUT_EN.
module exp_job_dispatcher
    import exp_pkg::*;
#(
    parameter int DW         = EXP_DW_DEF,
    parameter int START_HOLD = 2,
    parameter int CNT_W      = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_x,
    output logic             acc_start,
    output logic [DW-1:0]    acc_x,
    input  logic             acc_done,
    input  logic [DW-1:0]    acc_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_result,
    output logic             out_err,
    output logic             busy,
    output logic [CNT_W-1:0] jobs_done
);

    localparam int HOLD_CYC = exp_clamp_hold(START_HOLD);
    localparam logic [EXP_HOLD_W-1:0] HOLD_LD =
        EXP_HOLD_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] JOB_ONE = CNT_W'(1);

    exp_state_e       state_q;
    exp_state_e       state_d;
    logic [DW-1:0]    acc_x_q;
    logic [DW-1:0]    acc_x_d;
    logic [DW-1:0]    res_q;
    logic [DW-1:0]    res_d;
    logic             err_q;
    logic             err_d;
    logic [CNT_W-1:0] jobs_q;
    logic [CNT_W-1:0] jobs_d;

    logic hold_load;
    logic hold_dec;
    logic hold_zero;
    logic wd_load;
    logic wd_dec;
    logic wd_expired;

    exp_hold_counter #(
        .W (EXP_HOLD_W)
    ) u_hold (
        .clk        (clk),
        .rst        (rst),
        .load_i     (hold_load),
        .load_val_i (HOLD_LD),
        .dec_i      (hold_dec),
        .zero_o     (hold_zero)
    );

`ifdef EXP_DISPATCH_TIMEOUT_EN
    localparam int WD_CYC = (TIMEOUT < 1) ? 1 : TIMEOUT;
    localparam int WD_W   = $clog2(WD_CYC + 1);
    localparam logic [WD_W-1:0] WD_LD = WD_W'(WD_CYC - 1);

    logic wd_zero;

    // Loaded on WAIT entry, so it expires on the TIMEOUT-th WAIT cycle.
    exp_hold_counter #(
        .W (WD_W)
    ) u_wd (
        .clk        (clk),
        .rst        (rst),
        .load_i     (wd_load),
        .load_val_i (WD_LD),
        .dec_i      (wd_dec),
        .zero_o     (wd_zero)
    );

    assign wd_expired = wd_zero;
`else
    logic unused_wd;

    assign unused_wd  = wd_load ^ wd_dec ^ (TIMEOUT != 0);
    assign wd_expired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        acc_x_d   = acc_x_q;
        res_d     = res_q;
        err_d     = err_q;
        jobs_d    = jobs_q;
        hold_load = 1'b0;
        hold_dec  = 1'b0;
        wd_load   = 1'b0;
        wd_dec    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    acc_x_d   = in_x;
                    hold_load = 1'b1;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (hold_zero) begin
                    wd_load = 1'b1;
                    state_d = ST_WAIT;
                end else begin
                    hold_dec = 1'b1;
                end
            end
            ST_WAIT: begin
                // A done on the expiry cycle still counts as a result.
                if (acc_done) begin
                    res_d   = acc_result;
                    err_d   = 1'b0;
                    state_d = ST_OUT;
                end else if (wd_expired) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_OUT;
                end else begin
                    wd_dec = 1'b1;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    jobs_d  = jobs_q + JOB_ONE;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_x_q <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            jobs_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_x_q <= acc_x_d;
            res_q   <= res_d;
            err_q   <= err_d;
            jobs_q  <= jobs_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign acc_start  = (state_q == ST_LOAD);
    assign out_valid  = (state_q == ST_OUT);
    assign acc_x      = acc_x_q;
    assign out_result = res_q;
    assign out_err    = err_q;
    assign jobs_done  = jobs_q;

endmodule

// File: tb/tb_exp_job_dispatcher.sv
// Scoreboard bench for exp_job_dispatcher with a behavioural
// accelerator, random source and random sink.
module tb_exp_job_dispatcher;

    localparam int DW = 16;
    localparam int SH = 2;
    localparam int CW = 2;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_x;
    logic          acc_start;
    logic [DW-1:0] acc_x;
    logic          acc_done;
    logic [DW-1:0] acc_result;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_result;
    logic          out_err;
    logic          busy;
    logic [CW-1:0] jobs_done;

    always #5 clk = ~clk;

    exp_job_dispatcher #(
        .DW         (DW),
        .START_HOLD (SH),
        .CNT_W      (CW),
        .TIMEOUT    (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .acc_start  (acc_start),
        .acc_x      (acc_x),
        .acc_done   (acc_done),
        .acc_result (acc_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_err    (out_err),
        .busy       (busy),
        .jobs_done  (jobs_done)
    );

    typedef struct {
        logic [DW-1:0] res;
        logic          err;
        int            wlen;
    } exp_t;

    exp_t          sb_q[$];
    int            dir_lat[$];
    logic [DW-1:0] dir_res[$];
    int            cmp_n = 0;
    int            bad_n = 0;
    int            bp_req = 0;
    int            model_jobs = 0;
    logic [DW-1:0] acc_x_exp = '0;

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        cmp_n++;
        if (act != exp) begin
            bad_n++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_reset();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_acc_start", acc_start, 0);
        chk("rst_acc_x", acc_x, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_jobs_done", jobs_done, 0);
    endtask

    task automatic send(input logic [DW-1:0] x);
        bit ok;
        ok = 0;
        in_valid = 1'b1;
        in_x = x;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            cmp_n++;
            bad_n++;
            $display("FAIL send_accept: got none expected accept");
        end
    endtask

    // Accelerator: done k cycles into WAIT, stray dones otherwise.
    initial begin
        bit            sp;
        bit            active;
        int            wcnt;
        int            k;
        logic [DW-1:0] res;
        exp_t          e;
        sp = 0;
        active = 0;
        wcnt = 0;
        k = 0;
        acc_done = 1'b0;
        acc_result = '0;
        forever begin
            @(negedge clk);
            acc_done = 1'b0;
            if (rst) begin
                sp = 0;
                active = 0;
            end else begin
                if (sp && !acc_start) begin
                    if (dir_lat.size() > 0) begin
                        k = dir_lat.pop_front();
                        res = dir_res.pop_front();
                    end else begin
                        k = $urandom_range(1, 12);
                        res = DW'($urandom);
`ifdef EXP_DISPATCH_TIMEOUT_EN
                        if ($urandom_range(0, 5) == 0) k = 0;
`endif
                    end
                    active = 1;
                    wcnt = 1;
                    e.res = res;
                    e.err = 1'b0;
                    e.wlen = k;
`ifdef EXP_DISPATCH_TIMEOUT_EN
                    if (k == 0 || k > TO) begin
                        active = 0;
                        e.res = '0;
                        e.err = 1'b1;
                        e.wlen = TO;
                    end
`endif
                    sb_q.push_back(e);
                end else if (active) begin
                    wcnt++;
                end
                if (active && wcnt == k) begin
                    acc_done = 1'b1;
                    acc_result = res;
                    active = 0;
                end else if (!active && (acc_start || out_valid)
                             && $urandom_range(0, 3) == 0) begin
                    acc_done = 1'b1;
                    acc_result = DW'($urandom);
                end
                sp = acc_start;
            end
        end
    end

    // Sink with optional forced backpressure at the start of OUT.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (out_valid && bp_req > 0) begin
                out_ready = 1'b0;
                bp_req--;
            end else begin
                out_ready = ($urandom_range(0, 2) != 0);
            end
        end
    end

    // Monitor: protocol checks and scoreboard pops.
    initial begin
        int            run;
        int            wc;
        bit            waiting;
        bit            prev_ov;
        bit            prev_or;
        logic [DW-1:0] prev_res;
        logic          prev_err;
        exp_t          e;
        run = 0;
        wc = 0;
        waiting = 0;
        prev_ov = 0;
        prev_or = 0;
        prev_res = '0;
        prev_err = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb_q.delete();
                model_jobs = 0;
                run = 0;
                waiting = 0;
                prev_ov = 0;
                prev_or = 0;
            end else begin
                chk("jobs_done", jobs_done, model_jobs);
                chk("in_ready_idle", in_ready, !busy);
                if (acc_start) begin
                    run++;
                    chk("acc_x_load", acc_x, acc_x_exp);
                    chk("no_accept_load", in_ready, 0);
                end else if (run > 0) begin
                    chk("start_len", run, SH);
                    run = 0;
                    wc = 1;
                    waiting = 1;
                end else if (waiting) begin
                    wc++;
                end
                if (out_valid) begin
                    chk("no_start_in_out", acc_start, 0);
                    chk("no_accept_out", in_ready, 0);
                end
                if (out_valid && waiting) begin
                    waiting = 0;
                    if (sb_q.size() == 0) begin
                        chk("sb_empty_wait", 1, 0);
                    end else begin
                        chk("wait_len", wc - 1, sb_q[0].wlen);
                    end
                end
                if (out_valid && prev_ov && !prev_or) begin
                    chk("hold_result", out_result, prev_res);
                    chk("hold_err", out_err, prev_err);
                end
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_empty_pop", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("out_result", out_result, e.res);
                        chk("out_err", out_err, e.err);
                    end
                    model_jobs = (model_jobs + 1) % (1 << CW);
                end
                if (in_valid && in_ready) acc_x_exp = in_x;
                prev_ov = out_valid;
                prev_or = out_ready;
                prev_res = out_result;
                prev_err = out_err;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        rst = 1'b1;
        in_valid = 1'b0;
        in_x = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        dir_lat.push_back(10);
        dir_res.push_back(16'h1234);
        send(16'h0003);

        bp_req = 5;
        send(16'h0055);
        send(16'h0007);
`ifdef EXP_DISPATCH_TIMEOUT_EN
        dir_lat.push_back(TO);
        dir_res.push_back(16'hbeef);
        send(16'h0011);
        dir_lat.push_back(0);
        dir_res.push_back(16'h0000);
        send(16'h0012);
        dir_lat.push_back(TO + 1);
        dir_res.push_back(16'h0bad);
        send(16'h0013);
`endif
        repeat (40) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send(DW'($urandom));
        end

        send(16'h0a0a);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        repeat (6) send(DW'($urandom));

        ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !busy) ok = 1;
        end
        chk("drain", ok, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 cmp_n, bad_n);
        $finish;
    end

endmodule

// File: doc/exp_job_dispatcher.md
Name: exp_job_dispatcher

Overview:
Initiator side of the start/done handshake used by the iterative series-evaluation datapath controller. It accepts operand jobs on a valid/ready input stream and drives operand x plus start into the accelerator. It then waits for done, captures the result, and presents it on a valid/ready output stream. It sits between the system-side operand source and result sink and the accelerator's controller/datapath pair.

Parameters:
DW, 16, operand and result width
START_HOLD, 2, cycles start is held high (the accelerator needs ≥2: Idle→Initialization, then a load cycle); legal range 2..15
CNT_W, 8, width of completed-job counter
TIMEOUT, 255, WAIT-state watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand job available
in_ready  out  1  dispatcher can accept a job
in_x  in  DW  operand x
acc_start  out  1  start to accelerator controller
acc_x  out  DW  operand bus to datapath x register
acc_done  in  1  accelerator completion
acc_result  in  DW  accelerator result register value
out_valid  out  1  result available
out_ready  in  1  sink accepts result
out_result  out  DW  captured result
out_err  out  1  result invalid (timeout); 0 when the feature is absent
busy  out  1  state != IDLE
jobs_done  out  CNT_W  count of results handed off

Behaviour:
- Reset (synchronous, rst=1 at posedge): state=IDLE; in_ready=1; acc_start=0; acc_x=0; out_valid=0; out_result=0; out_err=0; busy=0; jobs_done=0; hold and watchdog counters=0. Reset mid-job abandons the job silently; the accelerator is reset separately.
- States: IDLE, LOAD, WAIT, OUT.
- IDLE: in_ready=1. When in_valid&in_ready, register in_x into acc_x and go to LOAD.
- LOAD: acc_start=1 for exactly START_HOLD consecutive cycles; acc_x held stable. After the last cycle go to WAIT with acc_start=0. The falling edge moves the accelerator from Initialization to Begin.
- WAIT: acc_start=0. On acc_done=1: out_result<=acc_result, out_err<=0, go to OUT. acc_done seen in IDLE/LOAD/OUT is ignored.
- OUT: out_valid=1. out_result and out_err are held until out_valid&out_ready. On that handshake: jobs_done+=1 (wraps at 2^CNT_W), go to IDLE. Back-to-back minimum job period = 1 + START_HOLD + accelerator latency + 1 cycles.
- in_ready=0 in every state except IDLE. The input handshake is never accepted while busy.
- Outputs are registered (Moore). acc_start is asserted from a registered state only; no combinational path from acc_done to any output.
- All counters are unsigned. The hold counter is wide enough for START_HOLD.

Optional Feature:
Macro EXP_DISPATCH_TIMEOUT_EN.
- With it: the watchdog counts cycles in WAIT, cleared on WAIT entry. If it reaches TIMEOUT without acc_done: out_result<=0, out_err<=1, go to OUT. acc_done arriving on the same cycle as the timeout wins (normal capture, err=0).
- Without it: WAIT lasts indefinitely; out_err is tied to 0; the TIMEOUT parameter is unused.

Decomposition:
- Shared package exp_pkg: state enum encoding (IDLE=0, LOAD=1, WAIT=2, OUT=3), default DW, START_HOLD minimum constant.
- One natural sub-module, exp_hold_counter: loadable down-counter with a zero flag. It is reused for the START_HOLD countdown and the watchdog.

Test Plan:
- Reset then idle: rst high 2 cycles → all outputs at reset values, in_ready=1, jobs_done=0.
- Single job: in_x=0x0003, in_valid 1 cycle; acc_done pulses 10 cycles after start falls with acc_result=0x1234 → acc_start high exactly 2 cycles, acc_x=0x0003 throughout LOAD; out_valid=1 with out_result=0x1234; jobs_done=1 after out_ready.
- Backpressure: hold out_ready=0 for 5 cycles in OUT while in_valid=1 with in_x=0x0007 → out_result stable, in_ready=0, no new acc_start until handoff.
- Spurious done: acc_done=1 during LOAD → ignored; capture only on the later done in WAIT.
- Counter wrap: CNT_W=2, 5 jobs → jobs_done sequence 1,2,3,0,1.
- Timeout (macro defined, TIMEOUT=8): no acc_done → OUT after 8 WAIT cycles with out_err=1, out_result=0. Repeat with acc_done on cycle 8 → out_err=0.
